// File: rtl/q_argmax_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | q_argmax_seq : sequential argmax/argmin over NUM_ACT Q-values, 1 elem/clk |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module q_argmax_seq #(
  parameter int DATA_W  = 32,
  parameter int NUM_ACT = 4,
  parameter int SIGNED  = 1,
  localparam int IDX_W  = $clog2(NUM_ACT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_ACT*DATA_W-1:0] q_vec,
  input  logic                      mode_min,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         best_q,
  output logic [IDX_W-1:0]          best_idx
);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_ACT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  logic [NUM_ACT*DATA_W-1:0]   r_q;
  logic                        r_min;
  logic [IDX_W-1:0]            r_k;
  logic [DATA_W-1:0]           r_best_q;
  logic [IDX_W-1:0]            r_best_idx;

  logic [DATA_W-1:0]           w_elem [NUM_ACT];
  logic [DATA_W-1:0]           w_cand;
  logic                        w_gt;
  logic                        w_lt;
  logic                        w_better;

  for (genvar g = 0; g < NUM_ACT; g++) begin : g_unpack
    assign w_elem[g] = r_q[g*DATA_W +: DATA_W];
  end

  assign w_cand = w_elem[r_k];

  if (SIGNED != 0) begin : g_signed
    assign w_gt = $signed(w_cand) > $signed(r_best_q);
    assign w_lt = $signed(w_cand) < $signed(r_best_q);
  end else begin : g_unsigned
    assign w_gt = w_cand > r_best_q;
    assign w_lt = w_cand < r_best_q;
  end

  // Strict compare: ties leave the earlier (lower) index in place.
  assign w_better = r_min ? w_lt : w_gt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_min      <= 1'b0;
      r_k        <= '0;
      r_best_q   <= '0;
      r_best_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q        <= q_vec;
            r_min      <= mode_min;
            r_best_q   <= q_vec[DATA_W-1:0];
            r_best_idx <= '0;
            r_k        <= IDX_W'(1);
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_better) begin
            r_best_q   <= w_cand;
            r_best_idx <= r_k;
          end
          if (r_k == c_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign best_q    = r_best_q;
  assign best_idx  = r_best_idx;

endmodule
`default_nettype wire

// File: tb/tb_q_argmax_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_q_argmax_seq : directed bench for q_argmax_seq (4x32 s/u, 8x16 s)      |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_q_argmax_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv4, mm4, or4;
  logic [127:0] q4;
  logic         ir_s, ov_s, ir_u, ov_u;
  logic [31:0]  bq_s, bq_u;
  logic [1:0]   bi_s, bi_u;

  logic         iv8, mm8, or8;
  logic [127:0] q8;
  logic         ir_w, ov_w;
  logic [15:0]  bq_w;
  logic [2:0]   bi_w;

  int total = 0;
  int bad   = 0;

  q_argmax_seq #(.DATA_W(32), .NUM_ACT(4), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir_s), .q_vec(q4),
    .mode_min(mm4), .out_valid(ov_s), .out_ready(or4), .best_q(bq_s), .best_idx(bi_s));

  q_argmax_seq #(.DATA_W(32), .NUM_ACT(4), .SIGNED(0)) u_u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir_u), .q_vec(q4),
    .mode_min(mm4), .out_valid(ov_u), .out_ready(or4), .best_q(bq_u), .best_idx(bi_u));

  q_argmax_seq #(.DATA_W(16), .NUM_ACT(8), .SIGNED(1)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir_w), .q_vec(q8),
    .mode_min(mm8), .out_valid(ov_w), .out_ready(or8), .best_q(bq_w), .best_idx(bi_w));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic accept4(input string tag, input logic [127:0] v, input logic m);
    chk({tag, "_rdy"}, 64'(ir_s), 64'd1);
    q4 = v; mm4 = m; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    chk({tag, "_busy"}, 64'(ir_s), 64'd0);
  endtask

  task automatic wait_s(input string tag, input int lat);
    int n;
    n = 0;
    while (ov_s !== 1'b1 && n < 20) begin
      chk({tag, "_scan_rdy"}, 64'(ir_s), 64'd0);
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  task automatic wait_w(input string tag, input int lat);
    int n;
    n = 0;
    while (ov_w !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
  endtask

  task automatic release4(input string tag);
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    chk({tag, "_ov_clr"}, 64'(ov_s), 64'd0);
    chk({tag, "_rdy_back"}, 64'(ir_s), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    iv4 = 1'b0; mm4 = 1'b0; or4 = 1'b0; q4 = '0;
    iv8 = 1'b0; mm8 = 1'b0; or8 = 1'b0; q8 = '0;
    tick(); tick();

    chk("rst_in_ready", 64'(ir_s), 64'd1);
    chk("rst_out_valid", 64'(ov_s), 64'd0);
    chk("rst_best_q", 64'(bq_s), 64'd0);
    chk("rst_best_idx", 64'(bi_s), 64'd0);
    chk("rst_w_ready", 64'(ir_w), 64'd1);
    chk("rst_w_valid", 64'(ov_w), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic max: {10,-5,30,7}
    accept4("basic", pack4(32'd10, -32'sd5, 32'd30, 32'd7), 1'b0);
    wait_s("basic", 3);
    chk("basic_q", 64'(bq_s), 64'd30);
    chk("basic_idx", 64'(bi_s), 64'd2);
    release4("basic");

    // Ties keep the lower index
    accept4("tie0", pack4(32'd8, 32'd8, 32'd3, 32'd8), 1'b0);
    wait_s("tie0", 3);
    chk("tie0_q", 64'(bq_s), 64'd8);
    chk("tie0_idx", 64'(bi_s), 64'd0);
    release4("tie0");

    accept4("tie1", pack4(32'd3, 32'd9, 32'd9, 32'd1), 1'b0);
    wait_s("tie1", 3);
    chk("tie1_q", 64'(bq_s), 64'd9);
    chk("tie1_idx", 64'(bi_s), 64'd1);
    release4("tie1");

    // Signedness: same vector into signed and unsigned instances
    accept4("sgn", pack4(32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd1), 1'b0);
    wait_s("sgn", 3);
    chk("sgn_s_q", 64'(bq_s), 64'h7FFF_FFFF);
    chk("sgn_s_idx", 64'(bi_s), 64'd1);
    chk("sgn_u_valid", 64'(ov_u), 64'd1);
    chk("sgn_u_q", 64'(bq_u), 64'h8000_0000);
    chk("sgn_u_idx", 64'(bi_u), 64'd0);
    release4("sgn");

    // Min mode; inputs scrambled right after accept must not matter
    accept4("min", pack4(32'd10, -32'sd5, 32'd30, 32'd7), 1'b1);
    q4 = pack4(32'd100, 32'd100, 32'd100, 32'd100);
    mm4 = 1'b0;
    wait_s("min", 3);
    chk("min_q", 64'(bq_s), 64'hFFFF_FFFB);
    chk("min_idx", 64'(bi_s), 64'd1);
    release4("min");

    // Backpressure with a second vector pending
    accept4("bp", pack4(32'd1, 32'd50, 32'd2, 32'd3), 1'b0);
    wait_s("bp", 3);
    q4 = pack4(-32'sd1, -32'sd2, -32'sd9, -32'sd3);
    mm4 = 1'b1;
    iv4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 64'(ov_s), 64'd1);
      chk("bp_hold_rdy", 64'(ir_s), 64'd0);
      chk("bp_hold_q", 64'(bq_s), 64'd50);
      chk("bp_hold_idx", 64'(bi_s), 64'd1);
    end
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    chk("bp_idle_rdy", 64'(ir_s), 64'd1);
    chk("bp_idle_valid", 64'(ov_s), 64'd0);
    tick();
    iv4 = 1'b0;
    chk("bp2_accepted", 64'(ir_s), 64'd0);
    wait_s("bp2", 3);
    chk("bp2_q", 64'(bq_s), 64'hFFFF_FFF7);
    chk("bp2_idx", 64'(bi_s), 64'd2);
    release4("bp2");

    // Same backpressure flow on the 8x16 instance
    // A = {5,-3,7,100,-100,7,100,2} -> max 100 at idx 3
    q8 = {16'd2, 16'd100, 16'd7, 16'hFF9C, 16'd100, 16'd7, 16'hFFFD, 16'd5};
    mm8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    chk("w_busy", 64'(ir_w), 64'd0);
    wait_w("w_a", 7);
    chk("w_a_q", 64'(bq_w), 64'd100);
    chk("w_a_idx", 64'(bi_w), 64'd3);
    // B = {4,-8,-7,0,-8,9,1,2} min -> -8 at idx 1
    q8 = {16'd2, 16'd1, 16'd9, 16'hFFF8, 16'd0, 16'hFFF9, 16'hFFF8, 16'd4};
    mm8 = 1'b1; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w_hold_valid", 64'(ov_w), 64'd1);
      chk("w_hold_rdy", 64'(ir_w), 64'd0);
      chk("w_hold_q", 64'(bq_w), 64'd100);
      chk("w_hold_idx", 64'(bi_w), 64'd3);
    end
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("w_idle_rdy", 64'(ir_w), 64'd1);
    tick();
    iv8 = 1'b0;
    chk("w_b_accepted", 64'(ir_w), 64'd0);
    wait_w("w_b", 7);
    chk("w_b_q", 64'(bq_w), 64'hFFF8);
    chk("w_b_idx", 64'(bi_w), 64'd1);
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("w_b_done", 64'(ov_w), 64'd0);

    // Reset mid-scan at k=2: outputs clear before the next clock edge
    accept4("rst", pack4(32'd9, 32'd8, 32'd7, 32'd6), 1'b0);
    tick();
    chk("rst_pre_q", 64'(bq_s), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov_s), 64'd0);
    chk("arst_q", 64'(bq_s), 64'd0);
    chk("arst_idx", 64'(bi_s), 64'd0);
    chk("arst_rdy", 64'(ir_s), 64'd1);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("arst_no_result", 64'(ov_s), 64'd0);
    accept4("fresh", pack4(32'd1, 32'd2, 32'd3, 32'd4), 1'b0);
    wait_s("fresh", 3);
    chk("fresh_q", 64'(bq_s), 64'd4);
    chk("fresh_idx", 64'(bi_s), 64'd3);
    release4("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/q_argmax_seq.md
# q_argmax_seq

Parametrised sequential argmax/argmin unit for the Q-learning datapath. It accepts a packed vector of NUM_ACT Q-values through a valid/ready handshake and scans it one element per cycle. It returns the extreme value and its action index through a second valid/ready handshake. It replaces fixed 2/4/8-way max-select muxes in policy (action) selection and max-Q computation, and supports any action count, any data width, signed or unsigned values, and max or min mode.

## Interface
- DATA_W, 32, width of one Q-value
- NUM_ACT, 4, number of candidates; legal range 2..256
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare
- IDX_W (localparam), $clog2(NUM_ACT), index width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  q_vec/mode_min valid
- in_ready  out  1  block idle, can accept
- q_vec  in  NUM_ACT*DATA_W  element k at bits [k*DATA_W +: DATA_W]
- mode_min  in  1  0 = find maximum, 1 = find minimum
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- best_q  out  DATA_W  extreme value
- best_idx  out  IDX_W  index of extreme value

## Operation
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, the block does the following, then enters SCAN:
  - registers q_vec and mode_min
  - sets best_q = element 0, best_idx = 0, k = 1
- SCAN, each cycle: compare element k against best_q and replace best_q/best_idx when the candidate is strictly better. After element NUM_ACT-1, go to DONE; otherwise k increments.
  - Strictly better means greater in max mode and less in min mode.
  - Ties keep the lower index.
- DONE: hold best_q/best_idx stable. On out_ready, go to IDLE.
- Compare is signed when SIGNED=1 and unsigned when SIGNED=0. There is no arithmetic, so there is no overflow or width growth.
- The input registers are the working copy. Changes on q_vec or mode_min after acceptance have no effect.
- in_valid is ignored outside IDLE. No data is dropped: the producer holds in_valid until in_ready.
- The scan counter width is IDX_W. It never exceeds NUM_ACT-1. No wrap-around is observable.
- Reset mid-SCAN or mid-DONE aborts the operation and discards the result. Nothing is output for the aborted transaction.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - best_q = 0
  - best_idx = 0
  - internal k and input registers = 0
- Accept edge = E0. SCAN occupies edges E0+1 .. E0+(NUM_ACT-1). out_valid rises after edge E0+(NUM_ACT-1).
  - For NUM_ACT=4, out_valid is high in the 3rd cycle after the accept cycle.
- A result completes on the edge where out_valid && out_ready. in_ready is high the following cycle. A new accept can occur on the next edge.
- Back-to-back throughput is one result per NUM_ACT+1 cycles when out_ready is held high.
- best_q/best_idx may change during SCAN. They are guaranteed only while out_valid=1.
- All outputs are registered or decoded from state. There is no combinational path from in_valid, q_vec or out_ready to any output.

## Test plan
- Basic max, NUM_ACT=4, SIGNED=1, mode_min=0, q_vec = {e0..e3} = {10, -5, 30, 7}
  - Required: best_q=30, best_idx=2.
  - out_valid rises exactly 3 cycles after the accept cycle.
  - in_ready is 0 from E0 until completion.
- Ties: q_vec = {8, 8, 3, 8}
  - Required: best_q=8, best_idx=0.
  - Variant {3, 9, 9, 1} requires best_idx=1.
- Signedness: q_vec = {0x80000000, 0x7FFFFFFF, 0, 1}
  - SIGNED=1 requires best_q=0x7FFFFFFF, best_idx=1.
  - SIGNED=0 requires best_q=0x80000000, best_idx=0.
- Min mode plus input isolation: mode_min=1, q_vec = {10, -5, 30, 7}; change q_vec to all 100 one cycle after accept.
  - Required: best_q=-5, best_idx=1.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles in DONE while in_valid stays high with a new vector.
  - Required: outputs stable, in_ready=0, no accept.
  - Release out_ready: the second vector is accepted in the cycle after completion, and its result is correct.
  - Repeat the whole test with NUM_ACT=8, DATA_W=16.
- Reset mid-SCAN: assert rst_n=0 at k=2.
  - Required: out_valid=0, best_q=0, best_idx=0 and in_ready=1 immediately, asynchronously.
  - After release, the fresh vector {1, 2, 3, 4} gives best_q=4, best_idx=3.
